mmul_arbiter: RTL and testbench

- Shares one `mmul` 3x3 matrix unit between `N_REQ` requesters.
- Round-robin arbitration picks a requester. The block latches that requester's operand pair and drives the unit's level-enable handshake (enable held until `done`, then dropped).
- The result returns to the winner tagged with its id. A cycle watchdog aborts a hung unit.
- Sits between the requester-side fabric and the single `mmul` instance. Shares `clk`/`reset` with it.

---
 rtl/mmul_pkg.sv | 17 +
 rtl/rr_pick.sv | 28 ++
 rtl/mmul_arbiter.sv | 120 ++++++++++++
 tb/tb_mmul_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_pkg.sv
// Shared constants, FSM state type and matrix element helper for the mmul arbiter.
package mmul_pkg;
  localparam int DIM    = 3;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = DIM * DIM * ELEM_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RELEASE
  } arb_state_t;

  // LSB position of element (i,j) inside a packed matrix.
  function automatic int elem_lsb(input int i, input int j);
    return (i * DIM + j) * ELEM_W;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, with wrap.
// Zero latency; also produces the pointer value that follows the winner.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  sel,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] nxt
);
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int off = N - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + off) % N);
      end
    end
    sel = '0;
    if (valid) sel[idx] = 1'b1;
    nxt = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
  end
endmodule

// File: rtl/mmul_arbiter.sv
// Round-robin share of one mmul unit: grant 1 cycle after req, response 1 cycle after done.
// No queueing; req is sampled only in IDLE, watchdog aborts a RUN lasting TIMEOUT cycles.
module mmul_arbiter
  import mmul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*MAT_W-1:0]     req_mat_a,
  input  logic [N_REQ*MAT_W-1:0]     req_mat_b,
  output logic [N_REQ-1:0]           grant,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [MAT_W-1:0]           rsp_data,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       mmul_enable,
  output logic [MAT_W-1:0]           mmul_mat_a,
  output logic [MAT_W-1:0]           mmul_mat_b,
  input  logic                       mmul_done,
  input  logic [MAT_W-1:0]           mmul_result
);
  localparam int IW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT);

  arb_state_t     state, state_nxt;
  logic [IW-1:0]  ptr;
  logic [WDW-1:0] wdog;

  logic             pick_valid;
  logic [N_REQ-1:0] pick_sel;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    pick_nxt;
  logic             do_grant, do_done, do_abort;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .sel   (pick_sel),
    .idx   (pick_idx),
    .nxt   (pick_nxt)
  );

  assign busy = (state == ST_RUN) || (state == ST_RELEASE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          do_grant  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // done takes priority over the watchdog limit on the same edge
        if (mmul_done) begin
          do_done   = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (wdog == WDW'(TIMEOUT - 1)) begin
          do_abort  = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!mmul_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      mmul_enable <= 1'b0;
      mmul_mat_a  <= '0;
      mmul_mat_b  <= '0;
      ptr         <= '0;
      wdog        <= '0;
    end else begin
      grant     <= do_grant ? pick_sel : '0;
      rsp_valid <= do_done | do_abort;
      if (do_grant) begin
        mmul_mat_a  <= req_mat_a[pick_idx * MAT_W +: MAT_W];
        mmul_mat_b  <= req_mat_b[pick_idx * MAT_W +: MAT_W];
        rsp_id      <= pick_idx;
        ptr         <= pick_nxt;
        wdog        <= '0;
        mmul_enable <= 1'b1;
      end
      if (state == ST_RUN && !do_done && !do_abort) wdog <= wdog + WDW'(1);
      if (do_done) begin
        rsp_data    <= mmul_result;
        rsp_err     <= 1'b0;
        mmul_enable <= 1'b0;
      end
      if (do_abort) begin
        rsp_data    <= '0;
        rsp_err     <= 1'b1;
        mmul_enable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mmul_arbiter.sv
// Directed bench for mmul_arbiter with a bench-driven mmul unit (N_REQ=4, TIMEOUT=64).
module tb_mmul_arbiter;
  import mmul_pkg::*;

  localparam logic [71:0] MAT_A = 72'h01_02_03_01_00_05_03_08_02;
  localparam logic [71:0] MAT_I = 72'h01_00_00_00_01_00_00_00_01;
  localparam logic [71:0] RES_L = 72'hA5_5A_11_22_33_44_55_66_77;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     req = '0;
  logic [287:0]   req_mat_a = '0;
  logic [287:0]   req_mat_b = '0;
  logic [3:0]     grant;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [71:0]    rsp_data;
  logic           rsp_err;
  logic           busy;
  logic           mmul_enable;
  logic [71:0]    mmul_mat_a;
  logic [71:0]    mmul_mat_b;
  logic           mmul_done = 1'b0;
  logic [71:0]    mmul_result = '0;

  int n_chk = 0;
  int n_bad = 0;

  mmul_arbiter #(.N_REQ(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_mat_a   (req_mat_a),
    .req_mat_b   (req_mat_b),
    .grant       (grant),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .mmul_enable (mmul_enable),
    .mmul_mat_a  (mmul_mat_a),
    .mmul_mat_b  (mmul_mat_b),
    .mmul_done   (mmul_done),
    .mmul_result (mmul_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the grant vector, or zero if none appears within the budget.
  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant != '0) begin
        g = grant;
        break;
      end
    end
  endtask

  // Behavioural stand-in for the matrix unit: 3x3 product with 8-bit wrap.
  function automatic logic [71:0] mat_mul(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] r;
    logic [7:0]  acc;
    r = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        acc = '0;
        for (int k = 0; k < DIM; k++)
          acc = acc + a[elem_lsb(i, k) +: 8] * b[elem_lsb(k, j) +: 8];
        r[elem_lsb(i, j) +: 8] = acc;
      end
    return r;
  endfunction

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_grant"}, 72'(grant), 72'h0);
    chk({pfx, "_rsp_valid"}, 72'(rsp_valid), 72'h0);
    chk({pfx, "_rsp_id"}, 72'(rsp_id), 72'h0);
    chk({pfx, "_rsp_data"}, rsp_data, 72'h0);
    chk({pfx, "_rsp_err"}, 72'(rsp_err), 72'h0);
    chk({pfx, "_busy"}, 72'(busy), 72'h0);
    chk({pfx, "_enable"}, 72'(mmul_enable), 72'h0);
    chk({pfx, "_mat_a"}, mmul_mat_a, 72'h0);
    chk({pfx, "_mat_b"}, mmul_mat_b, 72'h0);
  endtask

  logic [3:0]  g;
  logic [71:0] fair_a [4];
  int          cnt;
  int          rsp_seen;
  int          exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    fair_a[0] = 72'h11_00_00_00_00_00_00_00_01;
    fair_a[1] = 72'h22_00_00_00_00_00_00_00_02;
    fair_a[2] = 72'h33_00_00_00_00_00_00_00_03;
    fair_a[3] = 72'h44_00_00_00_00_00_00_00_04;

    // Reset values
    tick();
    tick();
    check_all_zero("rst");
    reset = 1'b0;

    // Single request on port 1 with A and identity
    req_mat_a[72 +: 72] = MAT_A;
    req_mat_b[72 +: 72] = MAT_I;
    req = 4'b0010;
    tick();
    chk("t1_grant", 72'(grant), 72'h2);
    chk("t1_enable", 72'(mmul_enable), 72'h1);
    chk("t1_busy", 72'(busy), 72'h1);
    chk("t1_mat_a", mmul_mat_a, MAT_A);
    chk("t1_mat_b", mmul_mat_b, MAT_I);
    req = '0;
    tick();
    chk("t1_grant_pulse", 72'(grant), 72'h0);
    tick();
    mmul_done   = 1'b1;
    mmul_result = mat_mul(mmul_mat_a, mmul_mat_b);
    tick();
    chk("t1_rsp_valid", 72'(rsp_valid), 72'h1);
    chk("t1_rsp_id", 72'(rsp_id), 72'h1);
    chk("t1_rsp_data", rsp_data, MAT_A);
    chk("t1_rsp_err", 72'(rsp_err), 72'h0);
    chk("t1_enable_off", 72'(mmul_enable), 72'h0);
    mmul_done = 1'b0;
    tick();
    chk("t1_rsp_pulse", 72'(rsp_valid), 72'h0);
    chk("t1_idle", 72'(busy), 72'h0);

    // Round-robin fairness from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) req_mat_a[k*72 +: 72] = fair_a[k];
    req = 4'b1111;
    for (int op = 0; op < 8; op++) begin
      wait_grant(g);
      chk($sformatf("rr_grant%0d", op), 72'(g), 72'(4'b0001 << exp_order[op]));
      chk($sformatf("rr_mat_a%0d", op), mmul_mat_a, fair_a[exp_order[op]]);
      tick();
      tick();
      mmul_done   = 1'b1;
      mmul_result = 72'(op + 1);
      tick();
      chk($sformatf("rr_rsp_valid%0d", op), 72'(rsp_valid), 72'h1);
      chk($sformatf("rr_rsp_id%0d", op), 72'(rsp_id), 72'(exp_order[op]));
      mmul_done = 1'b0;
    end
    req = '0;
    tick();

    // done arriving on the watchdog's final RUN edge wins
    req = 4'b0001;
    wait_grant(g);
    chk("lim_grant", 72'(g), 72'h1);
    req = '0;
    for (int i = 0; i < 63; i++) tick();
    chk("lim_no_early_rsp", 72'(rsp_valid), 72'h0);
    mmul_done   = 1'b1;
    mmul_result = RES_L;
    tick();
    chk("lim_rsp_valid", 72'(rsp_valid), 72'h1);
    chk("lim_rsp_err", 72'(rsp_err), 72'h0);
    chk("lim_rsp_data", rsp_data, RES_L);
    mmul_done = 1'b0;
    tick();

    // Timeout: the unit never answers
    req = 4'b0001;
    wait_grant(g);
    chk("to_grant", 72'(g), 72'h1);
    req = '0;
    cnt = 0;
    while (cnt < 100) begin
      tick();
      cnt++;
      if (rsp_valid) break;
    end
    chk("to_latency", 72'(cnt), 72'd64);
    chk("to_rsp_err", 72'(rsp_err), 72'h1);
    chk("to_rsp_data", rsp_data, 72'h0);
    chk("to_enable_off", 72'(mmul_enable), 72'h0);
    tick();
    chk("to_idle", 72'(busy), 72'h0);

    // Reset in the middle of RUN
    req = 4'b0100;
    wait_grant(g);
    chk("rm_grant", 72'(g), 72'h4);
    rsp_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid) rsp_seen++;
    end
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    check_all_zero("rm");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) rsp_seen++;
      if (grant != '0) break;
      tick();
    end
    chk("rm_no_rsp", 72'(rsp_seen), 72'h0);
    chk("rm_next_grant", 72'(grant), 72'h1);

    // Sticky done keeps the arbiter in RELEASE
    tick();
    tick();
    mmul_done   = 1'b1;
    mmul_result = 72'h5;
    tick();
    chk("st_rsp_valid", 72'(rsp_valid), 72'h1);
    chk("st_rsp_id", 72'(rsp_id), 72'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("st_grant_hold%0d", i), 72'(grant), 72'h0);
      chk($sformatf("st_busy_hold%0d", i), 72'(busy), 72'h1);
    end
    mmul_done = 1'b0;
    tick();
    chk("st_idle_busy", 72'(busy), 72'h0);
    chk("st_idle_grant", 72'(grant), 72'h0);
    tick();
    chk("st_next_grant", 72'(grant), 72'h2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
